// File: rtl/bin_to_dec_pkg.sv
// Shared types and constants for the binary-to-decimal one-hot pulser.
package bin_to_dec_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CODE_MIN = 1;
  localparam int CODE_MAX = 7;
  localparam int N_DEC    = 7;
endpackage

// File: rtl/bin_to_dec_timer.sv
// Loadable down-counter; done marks the last cycle of the loaded interval.
module bin_to_dec_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] r_count;

  // Stops at zero so an idle timer never wraps around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == W'(1));
endmodule

// File: rtl/bin_to_dec.sv
// Accepts a 4-bit code and pulses the matching o_dN line for HOLD_CYCLES, then idles GAP_CYCLES.
// Define BIN_TO_DEC_ERR_EN to flag codes 8..15 on o_err instead of running them as code 0.
module bin_to_dec
  import bin_to_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_b,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_d1,
  output logic       o_d2,
  output logic       o_d3,
  output logic       o_d4,
  output logic       o_d5,
  output logic       o_d6,
  output logic       o_d7,
  output logic       o_err
);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);

  state_t             r_state;
  logic               r_ready;
  logic               r_err;
  logic [N_DEC-1:0]   r_d;
  logic [N_DEC-1:0]   w_dec;
  logic               w_accept;
  logic               w_is_err;
  logic               w_load;
  logic               w_done;
  logic [CNT_W-1:0]   w_value;

  genvar gi;
  generate
    for (gi = 0; gi < N_DEC; gi++) begin : g_dec
      assign w_dec[gi] = (i_b == 4'(gi + CODE_MIN));
    end
  endgenerate

`ifdef BIN_TO_DEC_ERR_EN
  assign w_is_err = (i_b > 4'(CODE_MAX));
`else
  assign w_is_err = 1'b0;
`endif

  assign w_accept = r_ready & i_valid;
  assign w_load   = ((r_state == IDLE) && w_accept && !w_is_err) ||
                    ((r_state == HOLD) && w_done && (GAP_CYCLES != 0));
  assign w_value  = (r_state == IDLE) ? HOLD_LD : GAP_LD;

  bin_to_dec_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .value (w_value),
    .done  (w_done)
  );

  // o_ready is a register updated from the next state, so it never follows i_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_d     <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_is_err) begin
              r_err <= 1'b1;
            end else begin
              r_state <= HOLD;
              r_ready <= 1'b0;
              r_d     <= w_dec;
            end
          end
        end
        HOLD: begin
          if (w_done) begin
            r_d <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end else begin
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (w_done) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_d     <= '0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_err   = r_err;
  assign o_d1    = r_d[0];
  assign o_d2    = r_d[1];
  assign o_d3    = r_d[2];
  assign o_d4    = r_d[3];
  assign o_d5    = r_d[4];
  assign o_d6    = r_d[5];
  assign o_d7    = r_d[6];
endmodule

// File: tb/tb_bin_to_dec.sv
// Self-checking bench: table of codes through a scoreboard queue plus hand-written reset/gap-0 sequences.
module tb_bin_to_dec;
  localparam int H = 4;
  localparam int G = 1;

  typedef struct {
    logic [3:0] code;
    logic [6:0] exp_d;
    logic       exp_err;
    int         busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_b = 4'd0;
  logic       i_valid = 1'b0;
  logic       o_ready, o_err;
  logic       o_d1, o_d2, o_d3, o_d4, o_d5, o_d6, o_d7;
  logic [6:0] d;

  logic [3:0] g_b = 4'd0;
  logic       g_valid = 1'b0;
  logic       g_ready, g_err;
  logic       g_d1, g_d2, g_d3, g_d4, g_d5, g_d6, g_d7;
  logic [6:0] gd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  vec_t vt[12];
  vec_t sb[$];

  assign d  = {o_d7, o_d6, o_d5, o_d4, o_d3, o_d2, o_d1};
  assign gd = {g_d7, g_d6, g_d5, g_d4, g_d3, g_d2, g_d1};

  bin_to_dec #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .i_b(i_b), .i_valid(i_valid), .o_ready(o_ready),
    .o_d1(o_d1), .o_d2(o_d2), .o_d3(o_d3), .o_d4(o_d4), .o_d5(o_d5),
    .o_d6(o_d6), .o_d7(o_d7), .o_err(o_err)
  );

  bin_to_dec #(.HOLD_CYCLES(H), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .i_b(g_b), .i_valid(g_valid), .o_ready(g_ready),
    .o_d1(g_d1), .o_d2(g_d2), .o_d3(g_d3), .o_d4(g_d4), .o_d5(g_d5),
    .o_d6(g_d6), .o_d7(g_d7), .o_err(g_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, o_ready}, 32'd1);
  endtask

  // Drive one code; leaves i_valid high when keep is set.
  task automatic send(input vec_t v, input bit keep, output int acc);
    wait_ready();
    i_b = v.code;
    i_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) i_valid = 1'b0;
  endtask

  task automatic observe(input logic [3:0] next_b);
    vec_t v;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    v = sb.pop_front();
    i_b = next_b;
    for (int k = 1; k <= v.busy + 1; k++) begin
      @(negedge clk);
      chk($sformatf("ready c%0d k%0d", v.code, k), {31'd0, o_ready}, (k > v.busy) ? 32'd1 : 32'd0);
      chk($sformatf("d c%0d k%0d", v.code, k), {25'd0, d},
          (v.busy > 0 && k <= H) ? {25'd0, v.exp_d} : 32'd0);
      chk($sformatf("err c%0d k%0d", v.code, k), {31'd0, o_err},
          (k == 1) ? {31'd0, v.exp_err} : 32'd0);
    end
    $display("txn code=%0d exp_d=%b busy=%0d checks=%0d errors=%0d", v.code, v.exp_d, v.busy, checks, errors);
  endtask

  initial begin
    int acc;
    int acc_prev;
    vec_t v;
    vec_t seq[3];

    vt[0]  = '{4'd5, 7'b0010000, 1'b0, H + G};
    vt[1]  = '{4'd1, 7'b0000001, 1'b0, H + G};
    vt[2]  = '{4'd2, 7'b0000010, 1'b0, H + G};
    vt[3]  = '{4'd3, 7'b0000100, 1'b0, H + G};
    vt[4]  = '{4'd4, 7'b0001000, 1'b0, H + G};
    vt[5]  = '{4'd6, 7'b0100000, 1'b0, H + G};
    vt[6]  = '{4'd7, 7'b1000000, 1'b0, H + G};
    vt[7]  = '{4'd0, 7'b0000000, 1'b0, H + G};
`ifdef BIN_TO_DEC_ERR_EN
    vt[8]  = '{4'd9, 7'b0000000, 1'b1, 0};
    vt[9]  = '{4'd15, 7'b0000000, 1'b1, 0};
    vt[10] = '{4'd8, 7'b0000000, 1'b1, 0};
`else
    vt[8]  = '{4'd9, 7'b0000000, 1'b0, H + G};
    vt[9]  = '{4'd15, 7'b0000000, 1'b0, H + G};
    vt[10] = '{4'd8, 7'b0000000, 1'b0, H + G};
`endif
    vt[11] = '{4'd7, 7'b1000000, 1'b0, H + G};

    repeat (3) @(negedge clk);
    chk("rst ready", {31'd0, o_ready}, 32'd0);
    chk("rst d", {25'd0, d}, 32'd0);
    chk("rst err", {31'd0, o_err}, 32'd0);
    chk("rst g0 ready", {31'd0, g_ready}, 32'd0);
    rst = 1'b0;
    chk("rel ready", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    chk("rel ready+1", {31'd0, o_ready}, 32'd1);
    chk("rel g0 ready+1", {31'd0, g_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      send(vt[i], 1'b0, acc);
      observe(4'd0);
    end

    // Continuous i_valid with codes stepping 1, 7, 3.
    seq[0] = '{4'd1, 7'b0000001, 1'b0, H + G};
    seq[1] = '{4'd7, 7'b1000000, 1'b0, H + G};
    seq[2] = '{4'd3, 7'b0000100, 1'b0, H + G};
    wait_ready();
    acc_prev = 0;
    for (int i = 0; i < 3; i++) begin
      send(seq[i], (i < 2), acc);
      if (i > 0) chk($sformatf("spacing %0d", i), acc - acc_prev, 1 + H + G);
      acc_prev = acc;
      observe((i < 2) ? seq[i + 1].code : 4'd0);
    end

    // Reset two cycles into HOLD of code 6.
    v = '{4'd6, 7'b0100000, 1'b0, H + G};
    send(v, 1'b0, acc);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    chk("pre-rst d6", {25'd0, d}, 32'h20);
    #2 rst = 1'b1;
    #1;
    chk("async rst d", {25'd0, d}, 32'd0);
    chk("async rst ready", {31'd0, o_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst2 rel ready", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    chk("rst2 ready+1", {31'd0, o_ready}, 32'd1);
    chk("rst2 d", {25'd0, d}, 32'd0);
    $display("txn code=6 reset-mid-hold checks=%0d errors=%0d", checks, errors);

    // GAP_CYCLES=0 build: code 2.
    begin
      int n = 0;
      while (g_ready !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("g0 ready_wait", {31'd0, g_ready}, 32'd1);
      g_b = 4'd2;
      g_valid = 1'b1;
      @(posedge clk);
      #1 g_valid = 1'b0;
      for (int k = 1; k <= H + 1; k++) begin
        @(negedge clk);
        chk($sformatf("g0 d k%0d", k), {25'd0, gd}, (k <= H) ? 32'h02 : 32'd0);
        chk($sformatf("g0 ready k%0d", k), {31'd0, g_ready}, (k > H) ? 32'd1 : 32'd0);
        chk($sformatf("g0 err k%0d", k), {31'd0, g_err}, 32'd0);
      end
      $display("txn g0 code=2 checks=%0d errors=%0d", checks, errors);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
